// File: rtl/prefetch_stage.sv
`default_nettype none
// =============================================================================
// prefetch_stage : credit-based instruction prefetcher with redirect flush
// Revision: 1.0
// =============================================================================
module prefetch_stage #(
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [31:0] INST_NOP        = 32'h0000_0013,
  parameter logic [31:0] REGPC_NOP       = 32'hFFFF_FFFF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [31:0]                          wb_reg_pc,
  input  logic                                 wb_branch_hazard,
  output logic [31:0]                          id_reg_pc,
  output logic [31:0]                          id_inst,
  output logic [31:0]                          if_reg_pc,
  output logic                                 mem_start,
  input  logic                                 mem_ready,
  output logic [31:0]                          mem_addr,
  input  logic [31:0]                          mem_data,
  input  logic                                 mem_data_valid,
  input  logic                                 stall_flg,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]     queue_count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] C_DEPTH_S = SW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] C_DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [OW-1:0] C_MAX_O   = OW'(MAX_OUTSTANDING);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   id_reg_pc_q, id_reg_pc_d;
  logic [31:0]   id_inst_q, id_inst_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [31:0]   pc_mem_q   [QUEUE_DEPTH];
  logic [31:0]   inst_mem_q [QUEUE_DEPTH];

  logic          resp_valid, push, pop, not_empty;
  logic [SW-1:0] credit;

  // Credit counts queued entries plus responses still expected to be kept.
  always_comb begin
    not_empty  = (count_q != '0);
    resp_valid = mem_data_valid && (outst_q != '0);
    credit     = SW'(count_q) + SW'(outst_q) - SW'(discard_q);
    mem_start  = rst_n && mem_ready && (outst_q < C_MAX_O) &&
                 (wb_branch_hazard || (credit < C_DEPTH_S));
    mem_addr   = wb_branch_hazard ? wb_reg_pc : fetch_pc_q;
    push       = resp_valid && !wb_branch_hazard && (discard_q == '0);
    pop        = !stall_flg && !wb_branch_hazard && not_empty;
    if_reg_pc  = wb_branch_hazard ? wb_reg_pc :
                 (not_empty ? pc_mem_q[rd_ptr_q] : resp_pc_q);
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    discard_d   = discard_q;
    outst_d     = outst_q + OW'(mem_start) - OW'(resp_valid);
    id_reg_pc_d = REGPC_NOP;
    id_inst_d   = INST_NOP;

    if (mem_start) begin
      fetch_pc_d = mem_addr + 32'd4;
    end else if (wb_branch_hazard) begin
      fetch_pc_d = wb_reg_pc;
    end

    if (wb_branch_hazard) begin
      // Everything already in flight is stale; a same-cycle response is consumed here.
      discard_d = outst_q - OW'(resp_valid);
      resp_pc_d = wb_reg_pc;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      if (resp_valid && (discard_q != '0)) begin
        discard_d = discard_q - OW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (pop) begin
      id_reg_pc_d = pc_mem_q[rd_ptr_q];
      id_inst_d   = inst_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
      id_reg_pc_q <= REGPC_NOP;
      id_inst_q   <= INST_NOP;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      id_reg_pc_q <= id_reg_pc_d;
      id_inst_q   <= id_inst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      inst_mem_q[wr_ptr_q] <= mem_data;
    end
  end

  // The credit rule makes a push into a full, non-draining queue unreachable.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (count_q == C_DEPTH_C)));
    end
  end

  assign id_reg_pc   = id_reg_pc_q;
  assign id_inst     = id_inst_q;
  assign queue_count = count_q;
  assign outstanding = outst_q;

endmodule
`default_nettype wire

// File: tb/tb_prefetch_stage.sv
`default_nettype none
// =============================================================================
// tb_prefetch_stage : directed self-checking bench for prefetch_stage
// Revision: 1.0
// =============================================================================
module tb_prefetch_stage;

  localparam logic [31:0] C_NOP_PC = 32'hFFFF_FFFF;
  localparam logic [31:0] C_NOP_IN = 32'h0000_0013;
  localparam logic [31:0] C_TAG    = 32'h0BAD_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wb_reg_pc;
  logic        wb_branch_hazard;
  logic [31:0] id_reg_pc, id_inst, if_reg_pc, mem_addr, mem_data;
  logic        mem_start, mem_ready, mem_data_valid, stall_flg;
  logic [2:0]  queue_count;
  logic [1:0]  outstanding;

  logic [31:0] w_id_reg_pc, w_id_inst, w_if_reg_pc, w_mem_addr;
  logic        w_mem_start;
  logic [2:0]  w_queue_count;
  logic [1:0]  w_outstanding;
  logic [31:0] w_zero32;
  logic        w_zero, w_one;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prefetch_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .wb_reg_pc(wb_reg_pc), .wb_branch_hazard(wb_branch_hazard),
    .id_reg_pc(id_reg_pc), .id_inst(id_inst), .if_reg_pc(if_reg_pc),
    .mem_start(mem_start), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .stall_flg(stall_flg), .queue_count(queue_count), .outstanding(outstanding)
  );

  prefetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .wb_reg_pc(w_zero32), .wb_branch_hazard(w_zero),
    .id_reg_pc(w_id_reg_pc), .id_inst(w_id_inst), .if_reg_pc(w_if_reg_pc),
    .mem_start(w_mem_start), .mem_ready(w_one), .mem_addr(w_mem_addr),
    .mem_data(w_zero32), .mem_data_valid(w_zero),
    .stall_flg(w_zero), .queue_count(w_queue_count), .outstanding(w_outstanding)
  );

  // Memory: in-order, one-cycle latency, data = address + tag; mem_hold withholds responses.
  logic [31:0] pend [$];
  int          pend_cnt;
  logic [31:0] head_addr;
  logic        mem_hold;

  assign mem_data_valid = !mem_hold && (pend_cnt > 0);
  assign mem_data       = head_addr + C_TAG;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      pend_cnt  <= 0;
      head_addr <= 32'h0;
    end else begin
      if (mem_data_valid) void'(pend.pop_front());
      if (mem_start) pend.push_back(mem_addr);
      pend_cnt  <= pend.size();
      head_addr <= (pend.size() > 0) ? pend[0] : 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w_zero32 = 32'h0; w_zero = 1'b0; w_one = 1'b1;
    rst_n = 1'b0; wb_reg_pc = 32'h0; wb_branch_hazard = 1'b0;
    stall_flg = 1'b0; mem_ready = 1'b1; mem_hold = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_qcount", 32'(queue_count), 32'd0);
    chk("rst_outst", 32'(outstanding), 32'd0);
    chk("rst_id_pc", id_reg_pc, C_NOP_PC);
    chk("rst_id_inst", id_inst, C_NOP_IN);
    chk("rst_start", 32'(mem_start), 32'd0);
    chk("rst_if_pc", if_reg_pc, 32'h0);

    rst_n = 1'b1;
    #1;
    chk("first_start", 32'(mem_start), 32'd1);
    chk("first_addr", mem_addr, 32'h0);
    chk("wrap_addr0", w_mem_addr, 32'hFFFF_FFF8);

    step(); // edge 1
    chk("e1_addr", mem_addr, 32'h4);
    chk("e1_outst", 32'(outstanding), 32'd1);
    chk("e1_id_pc", id_reg_pc, C_NOP_PC);
    chk("wrap_addr1", w_mem_addr, 32'hFFFF_FFFC);

    step(); // edge 2
    chk("e2_qcount", 32'(queue_count), 32'd1);
    chk("e2_if_pc", if_reg_pc, 32'h0);
    chk("wrap_addr2", w_mem_addr, 32'h0);
    chk("wrap_start_cap", 32'(w_mem_start), 32'd0);

    step(); // edge 3
    chk("e3_id_pc", id_reg_pc, 32'h0);
    chk("e3_id_inst", id_inst, C_TAG);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("stream_id_pc", id_reg_pc, 32'(4 * k));
      chk("stream_id_inst", id_inst, 32'(4 * k) + C_TAG);
    end

    // Decode stall for six cycles.
    stall_flg = 1'b1;
    repeat (3) step();
    chk("stall_fill", 32'(queue_count), 32'd4);
    repeat (3) step();
    chk("stall_qcount", 32'(queue_count), 32'd4);
    chk("stall_start", 32'(mem_start), 32'd0);
    chk("stall_outst", 32'(outstanding), 32'd0);
    chk("stall_id_pc", id_reg_pc, C_NOP_PC);
    stall_flg = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("unstall_id_pc", id_reg_pc, 32'h10 + 32'(4 * k));
    end

    // Redirect with two requests in flight.
    mem_hold = 1'b1;
    step();
    chk("hold_id_pc", id_reg_pc, 32'h24);
    step();
    chk("hold_id_pc2", id_reg_pc, 32'h28);
    chk("hold_outst", 32'(outstanding), 32'd2);
    chk("hold_qcount", 32'(queue_count), 32'd0);
    wb_branch_hazard = 1'b1;
    wb_reg_pc = 32'h100;
    #1;
    chk("hz_addr", mem_addr, 32'h100);
    chk("hz_if_pc", if_reg_pc, 32'h100);
    chk("hz_start", 32'(mem_start), 32'd0);
    step();
    wb_branch_hazard = 1'b0;
    mem_hold = 1'b0;
    chk("hz_id_pc", id_reg_pc, C_NOP_PC);
    chk("hz_outst", 32'(outstanding), 32'd2);
    step();
    chk("drop1_id_pc", id_reg_pc, C_NOP_PC);
    chk("drop1_outst", 32'(outstanding), 32'd1);
    chk("refetch_start", 32'(mem_start), 32'd1);
    chk("refetch_addr", mem_addr, 32'h100);
    step();
    chk("drop2_id_pc", id_reg_pc, C_NOP_PC);
    step();
    chk("empty_id_pc", id_reg_pc, C_NOP_PC);
    step();
    chk("redir_id_pc", id_reg_pc, 32'h100);
    chk("redir_id_inst", id_inst, 32'h100 + C_TAG);
    step();
    chk("redir_id_pc2", id_reg_pc, 32'h104);

    // Redirect coinciding with a response and a new request.
    chk("pre_outst", 32'(outstanding), 32'd1);
    wb_branch_hazard = 1'b1;
    wb_reg_pc = 32'h100;
    #1;
    chk("co_start", 32'(mem_start), 32'd1);
    chk("co_addr", mem_addr, 32'h100);
    step();
    wb_branch_hazard = 1'b0;
    #1;
    chk("co_outst", 32'(outstanding), 32'd1);
    chk("co_qcount", 32'(queue_count), 32'd0);
    chk("co_next_addr", mem_addr, 32'h104);
    chk("co_id_pc", id_reg_pc, C_NOP_PC);
    step();
    chk("co_kept_qcount", 32'(queue_count), 32'd1);
    step();
    chk("co_id_pc2", id_reg_pc, 32'h100);
    step();
    chk("co_id_pc3", id_reg_pc, 32'h104);

    // Reset while the queue is full.
    stall_flg = 1'b1;
    repeat (4) step();
    chk("full_qcount", 32'(queue_count), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("mrst_qcount", 32'(queue_count), 32'd0);
    chk("mrst_outst", 32'(outstanding), 32'd0);
    chk("mrst_id_pc", id_reg_pc, C_NOP_PC);
    chk("mrst_id_inst", id_inst, C_NOP_IN);
    chk("mrst_start", 32'(mem_start), 32'd0);
    stall_flg = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_refetch_start", 32'(mem_start), 32'd1);
    chk("mrst_refetch_addr", mem_addr, 32'h0);
    repeat (3) step();
    chk("mrst_id_pc0", id_reg_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
